// File: rtl/mbikovitsky_lfsr_pkg.sv
// Shared definitions for the 5-bit Galois LFSR generator and its checker.
// Both ends use the same width and checker state encoding.
package mbikovitsky_lfsr_pkg;

    localparam int LFSR_BITS = 5;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

endpackage

// File: rtl/mbikovitsky_lfsr_step.sv
// One Galois LFSR advance: shift right, fold in the taps when bit 0 was set.
// Shared by the generator and the checker so both ends step identically.
module mbikovitsky_lfsr_step #(
    parameter int W = 5
) (
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_taps,
    output logic [W-1:0] o_next
);

    assign o_next = (i_x >> 1) ^ (i_x[0] ? i_taps : '0);

endmodule

// File: rtl/mbikovitsky_lfsr_checker.sv
// Receive-side LFSR checker: locks onto the sampled sequence, then
// flywheels on its own prediction and counts mismatches.
module mbikovitsky_lfsr_checker
    import mbikovitsky_lfsr_pkg::*;
#(
    parameter int                 LFSR_BITS    = mbikovitsky_lfsr_pkg::LFSR_BITS,
    parameter logic [LFSR_BITS-1:0] TAPS_RESET = 5'h12,
    parameter int                 LOCK_COUNT   = 3,
    parameter int                 UNLOCK_COUNT = 3,
    parameter int                 ERR_BITS     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 taps_load,
    input  logic                 sample_valid,
    input  logic [LFSR_BITS-1:0] data_in,
    output logic                 locked,
    output logic                 mismatch,
    output logic [ERR_BITS-1:0]  err_count,
    output logic [LFSR_BITS-1:0] predicted
);

    localparam int CMAX = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
    localparam int CW   = $clog2(CMAX) + 1;
    localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_COUNT - 1);
    localparam logic [CW-1:0] UNLOCK_LAST = CW'(UNLOCK_COUNT - 1);

    chk_state_t           r_state, w_state_nxt;
    logic [LFSR_BITS-1:0] r_taps, w_taps_nxt;
    logic [LFSR_BITS-1:0] r_pred, w_pred_nxt;
    logic [CW-1:0]        r_match, w_match_nxt;
    logic [CW-1:0]        r_miss, w_miss_nxt;
    logic [ERR_BITS-1:0]  r_err, w_err_nxt;
    logic                 r_locked, w_locked_nxt;
    logic                 r_mm, w_mm_nxt;

    logic [LFSR_BITS-1:0] w_step_data;
    logic [LFSR_BITS-1:0] w_step_pred;
    logic                 w_hit;
    logic                 w_err_sat;

    mbikovitsky_lfsr_step #(.W(LFSR_BITS)) u_step_data (
        .i_x    (data_in),
        .i_taps (r_taps),
        .o_next (w_step_data)
    );

    mbikovitsky_lfsr_step #(.W(LFSR_BITS)) u_step_pred (
        .i_x    (r_pred),
        .i_taps (r_taps),
        .o_next (w_step_pred)
    );

    assign w_hit     = (data_in == r_pred);
    assign w_err_sat = &r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= HUNT;
            r_taps   <= TAPS_RESET;
            r_pred   <= '0;
            r_match  <= '0;
            r_miss   <= '0;
            r_err    <= '0;
            r_locked <= 1'b0;
            r_mm     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_taps   <= w_taps_nxt;
            r_pred   <= w_pred_nxt;
            r_match  <= w_match_nxt;
            r_miss   <= w_miss_nxt;
            r_err    <= w_err_nxt;
            r_locked <= w_locked_nxt;
            r_mm     <= w_mm_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_taps_nxt   = r_taps;
        w_pred_nxt   = r_pred;
        w_match_nxt  = r_match;
        w_miss_nxt   = r_miss;
        w_err_nxt    = r_err;
        w_locked_nxt = r_locked;
        w_mm_nxt     = 1'b0;

        if (taps_load) begin
            // A coincident sample is dropped; the error tally survives.
            w_taps_nxt   = data_in;
            w_state_nxt  = HUNT;
            w_match_nxt  = '0;
            w_miss_nxt   = '0;
            w_pred_nxt   = '0;
            w_locked_nxt = 1'b0;
        end else if (sample_valid) begin
            unique case (r_state)
                HUNT: begin
                    if (data_in != '0) begin
                        w_pred_nxt  = w_step_data;
                        w_match_nxt = '0;
                        w_state_nxt = VERIFY;
                    end
                end
                VERIFY: begin
                    w_pred_nxt = w_step_data;
                    if (w_hit) begin
                        if (r_match == LOCK_LAST) begin
                            w_state_nxt  = LOCKED;
                            w_locked_nxt = 1'b1;
                            w_miss_nxt   = '0;
                        end else begin
                            w_match_nxt = r_match + 1'b1;
                        end
                    end else begin
                        w_match_nxt = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: never reseed from the incoming sample.
                    w_pred_nxt = w_step_pred;
                    if (w_hit) begin
                        w_miss_nxt = '0;
                    end else begin
                        w_mm_nxt = 1'b1;
                        if (!w_err_sat) begin
                            w_err_nxt = r_err + 1'b1;
                        end
                        if (r_miss == UNLOCK_LAST) begin
                            w_state_nxt  = HUNT;
                            w_locked_nxt = 1'b0;
                            w_pred_nxt   = '0;
                            w_miss_nxt   = '0;
                            w_match_nxt  = '0;
                        end else begin
                            w_miss_nxt = r_miss + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = HUNT;
                end
            endcase
        end
    end

    assign locked    = r_locked;
    assign mismatch  = r_mm;
    assign err_count = r_err;
    assign predicted = r_pred;

endmodule

// File: tb/tb_mbikovitsky_lfsr_checker.sv
// Self-checking bench for the LFSR checker: directed scenarios plus
// randomized traffic against a behavioural model of the sequence tracker.
module tb_mbikovitsky_lfsr_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       taps_load;
    logic       sample_valid;
    logic [4:0] data_in;
    logic       locked;
    logic       mismatch;
    logic [7:0] err_count;
    logic [4:0] predicted;

    int n_tests = 0;
    int n_fail  = 0;

    mbikovitsky_lfsr_checker dut (
        .clk          (clk),
        .reset        (reset),
        .taps_load    (taps_load),
        .sample_valid (sample_valid),
        .data_in      (data_in),
        .locked       (locked),
        .mismatch     (mismatch),
        .err_count    (err_count),
        .predicted    (predicted)
    );

    always #5 clk = ~clk;

    // Reference model: "tracking" after a nonzero seed, "locked" after
    // enough confirmations; streaks count consecutive hits or misses.
    bit          m_tracking;
    bit          m_locked;
    int unsigned m_taps;
    int unsigned m_expect;
    int unsigned m_hits;
    int unsigned m_misses;
    int unsigned m_errors;
    bit          m_pulse;

    function automatic int unsigned ref_step(int unsigned x, int unsigned t);
        return (x / 2) ^ (((x % 2) == 1) ? t : 0);
    endfunction

    task automatic chk(input string tag, input int unsigned got,
                       input int unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model(input bit rst, input bit tl, input bit sv,
                         input int unsigned d);
        m_pulse = 1'b0;
        if (rst) begin
            m_tracking = 0; m_locked = 0; m_taps = 'h12;
            m_expect = 0; m_hits = 0; m_misses = 0; m_errors = 0;
        end else if (tl) begin
            m_tracking = 0; m_locked = 0; m_taps = d;
            m_expect = 0; m_hits = 0; m_misses = 0;
        end else if (sv) begin
            if (m_locked) begin
                if (d == m_expect) begin
                    m_misses = 0;
                    m_expect = ref_step(m_expect, m_taps);
                end else begin
                    m_pulse = 1'b1;
                    if (m_errors < 255) m_errors++;
                    m_misses++;
                    if (m_misses == 3) begin
                        m_locked = 0; m_tracking = 0;
                        m_expect = 0; m_misses = 0; m_hits = 0;
                    end else begin
                        m_expect = ref_step(m_expect, m_taps);
                    end
                end
            end else if (m_tracking) begin
                if (d == m_expect) begin
                    m_hits++;
                    if (m_hits == 3) begin
                        m_locked = 1; m_misses = 0;
                    end
                end else begin
                    m_hits = 0;
                end
                m_expect = ref_step(d, m_taps);
            end else if (d != 0) begin
                m_tracking = 1; m_hits = 0;
                m_expect = ref_step(d, m_taps);
            end
        end
    endtask

    task automatic cyc(input bit rst, input bit tl, input bit sv,
                       input int unsigned d);
        reset = rst; taps_load = tl; sample_valid = sv; data_in = 5'(d);
        @(posedge clk);
        model(rst, tl, sv, d);
        #1;
        chk("locked",    32'(locked),    32'(m_locked));
        chk("mismatch",  32'(mismatch),  32'(m_pulse));
        chk("err_count", 32'(err_count), m_errors);
        chk("predicted", 32'(predicted), m_expect);
        reset = 0; taps_load = 0; sample_valid = 0;
    endtask

    task automatic sample(input int unsigned d);
        cyc(0, 0, 1, d);
    endtask

    initial begin
        int unsigned r;
        int unsigned d;
        reset = 1; taps_load = 0; sample_valid = 0; data_in = 0;
        #2;

        // Reset state
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_pred",   32'(predicted), 0);

        // Acquire on 01,12,09,16
        sample('h01); sample('h12); sample('h09);
        chk("pre_lock", 32'(locked), 0);
        sample('h16);
        chk("lock", 32'(locked), 1);
        chk("lock_pred", 32'(predicted), 'h0B);

        // Single wrong sample while locked
        sample('h1F);
        chk("mm_pulse", 32'(mismatch), 1);
        chk("mm_err", 32'(err_count), 1);
        chk("mm_pred", 32'(predicted), 'h17);
        sample('h17);
        chk("hit_after", 32'(mismatch), 0);
        chk("hit_lock", 32'(locked), 1);

        // Three misses drop lock, then zero keeps hunting
        sample(m_expect ^ 1); sample(m_expect ^ 1); sample(m_expect ^ 1);
        chk("unlock", 32'(locked), 0);
        chk("unlock_err", 32'(err_count), 4);
        sample(0);
        chk("zero_pred", 32'(predicted), 0);

        // Idle cycles hold everything
        cyc(0, 0, 0, 'h1F); cyc(0, 0, 0, 'h03);

        // Taps load beats a coincident sample
        cyc(0, 1, 1, 'h14);
        chk("tl_err", 32'(err_count), 4);
        chk("tl_pred", 32'(predicted), 0);
        sample('h01);
        chk("tl_taps", 32'(predicted), 'h14);
        sample('h14); sample('h0A); sample('h05);
        chk("tl_lock", 32'(locked), 1);

        // Saturation: hit, miss, miss repeated keeps lock while errors pile up
        for (int i = 0; i < 150; i++) begin
            sample(m_expect);
            sample(m_expect ^ 2);
            sample(m_expect ^ 2);
        end
        chk("sat_err", 32'(err_count), 255);
        chk("sat_lock", 32'(locked), 1);

        // Back to default taps for random traffic
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 999);
            d = $urandom_range(0, 31);
            if (r < 5) begin
                cyc(1, 0, 0, 0);
            end else if (r < 15) begin
                cyc(0, 1, $urandom_range(0, 1), d);
            end else if (r < 300) begin
                cyc(0, 0, 0, d);
            end else if (r < 900 && (m_tracking || m_locked)) begin
                sample(m_expect);
            end else if (r < 900) begin
                sample((d == 0) ? 1 : d);
            end else begin
                sample(d);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
